// File: rtl/ring_pkg.sv
// Shared ring slot encodings and bus widths.
// Used by the client-side and memory-side ring arbiters.
package ring_pkg;

  localparam int RingW = 32;
  localparam int TypeW = 4;
  localparam int SdW   = 4;

  localparam logic [TypeW-1:0] Null      = 4'd7;
  localparam logic [TypeW-1:0] Token     = 4'd1;
  localparam logic [TypeW-1:0] Address   = 4'd2;
  localparam logic [TypeW-1:0] WriteData = 4'd3;
  localparam logic [TypeW-1:0] ReadData  = 4'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] win,
  output logic         valid
);

  int idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_client_arbiter.sv
// Shares one ring station among local clients; grants
// ownership on a Token, round-robin, with a hold watchdog.
module ring_client_arbiter
  import ring_pkg::*;
#(
  parameter int NCLIENT = 4,
  parameter int MAXHOLD = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [RingW-1:0]         RingIn,
  input  logic [TypeW-1:0]         SlotTypeIn,
  input  logic [SdW-1:0]           SrcDestIn,
  input  logic [NCLIENT-1:0]       req,
  input  logic [NCLIENT-1:0]       rel,
  input  logic [RingW*NCLIENT-1:0] cRingOut,
  input  logic [TypeW*NCLIENT-1:0] cSlotTypeOut,
  input  logic [SdW*NCLIENT-1:0]   cSrcDestOut,
  input  logic [NCLIENT-1:0]       cDrive,
  output logic [NCLIENT-1:0]       grant,
  output logic [NCLIENT-1:0]       waiting,
  output logic [RingW-1:0]         RingOut,
  output logic [TypeW-1:0]         SlotTypeOut,
  output logic [SdW-1:0]           SrcDestOut,
  output logic                     timeout,
  output logic                     protoErr
);

  localparam int PW = $clog2(NCLIENT);
  localparam int HW = $clog2(MAXHOLD + 1);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [PW-1:0] LAST    = PW'(NCLIENT - 1);
  localparam logic [HW-1:0] HOLDMAX = HW'(MAXHOLD);
  localparam logic [HW-1:0] HOLDLIM = HW'(MAXHOLD - 1);

  logic [0:0]         state;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      rrPtr;
  logic [HW-1:0]      holdCnt;
  logic [NCLIENT-1:0] pickWin;
  logic               pickValid;
  logic [PW-1:0]      winIdx;
  logic [PW-1:0]      nextPtr;
  logic               tokenIn;

  assign tokenIn = (SlotTypeIn == Token);
  assign nextPtr = (owner == LAST) ? '0 : owner + 1'b1;

  rr_pick #(.N(NCLIENT), .W(PW)) uPick (
    .req  (req),
    .ptr  (rrPtr),
    .win  (pickWin),
    .valid(pickValid)
  );

  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NCLIENT; i++)
      if (pickWin[i]) winIdx = PW'(i);
  end

  always_comb begin
    grant = '0;
    if (state == OWN)
      grant[owner] = 1'b1;
    else if (tokenIn && pickValid)
      grant = pickWin;
  end

  // Unregistered mux keeps station latency unchanged
  always_comb begin
    RingOut     = RingIn;
    SlotTypeOut = SlotTypeIn;
    SrcDestOut  = SrcDestIn;
    for (int i = 0; i < NCLIENT; i++) begin
      if (grant[i] && cDrive[i]) begin
        RingOut     = cRingOut[RingW*i +: RingW];
        SlotTypeOut = cSlotTypeOut[TypeW*i +: TypeW];
        SrcDestOut  = cSrcDestOut[SdW*i +: SdW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= HUNT;
      owner    <= '0;
      rrPtr    <= '0;
      holdCnt  <= '0;
      waiting  <= '0;
      timeout  <= 1'b0;
      protoErr <= 1'b0;
    end else begin
      waiting <= req & ~grant;
      timeout <= 1'b0;
      if (|(cDrive & ~grant)) protoErr <= 1'b1;
      case (state)
        HUNT: begin
          if (tokenIn && pickValid) begin
            owner   <= winIdx;
            state   <= OWN;
            holdCnt <= '0;
          end
        end
        default: begin
          if (holdCnt != HOLDMAX) holdCnt <= holdCnt + 1'b1;
          if (rel[owner]) begin
            state <= HUNT;
            rrPtr <= nextPtr;
          end else if (holdCnt == HOLDLIM) begin
            state   <= HUNT;
            rrPtr   <= nextPtr;
            timeout <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_client_arbiter.sv
// Randomized and directed bench for ring_client_arbiter
// against a cycle-level reference model.
module tb_ring_client_arbiter;
  import ring_pkg::*;

  localparam int N  = 4;
  localparam int MH = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [31:0]    RingIn;
  logic [3:0]     SlotTypeIn, SrcDestIn;
  logic [N-1:0]   req, rel, cDrive, grant, waiting;
  logic [32*N-1:0] cRingOut;
  logic [4*N-1:0] cSlotTypeOut, cSrcDestOut;
  logic [31:0]    RingOut;
  logic [3:0]     SlotTypeOut, SrcDestOut;
  logic           timeout, protoErr;

  int nTests = 0;
  int nFail  = 0;

  int           mOwner, mPtr, mHeld;
  logic [N-1:0] mWait;
  logic         mTo, mErr;
  int           lastWin;
  int           toCount;
  logic [N-1:0] pend;

  always #5 clock = ~clock;

  ring_client_arbiter #(.NCLIENT(N), .MAXHOLD(MH)) dut (
    .clock       (clock),
    .reset       (reset),
    .RingIn      (RingIn),
    .SlotTypeIn  (SlotTypeIn),
    .SrcDestIn   (SrcDestIn),
    .req         (req),
    .rel         (rel),
    .cRingOut    (cRingOut),
    .cSlotTypeOut(cSlotTypeOut),
    .cSrcDestOut (cSrcDestOut),
    .cDrive      (cDrive),
    .grant       (grant),
    .waiting     (waiting),
    .RingOut     (RingOut),
    .SlotTypeOut (SlotTypeOut),
    .SrcDestOut  (SrcDestOut),
    .timeout     (timeout),
    .protoErr    (protoErr)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pickFrom(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic modelReset();
    mOwner = -1; mPtr = 0; mHeld = 0;
    mWait = '0; mTo = 1'b0; mErr = 1'b0;
  endtask

  task automatic runCycle(input logic rst, input logic [N-1:0] rq,
                          input logic [N-1:0] rl, input logic [N-1:0] dr,
                          input logic [3:0] st);
    int w;
    logic [N-1:0] eg;
    logic [31:0] eRing;
    logic [3:0] eSt, eSd;
    reset = rst; req = rq; rel = rl; cDrive = dr; SlotTypeIn = st;
    RingIn = $urandom;
    SrcDestIn = 4'($urandom);
    for (int i = 0; i < N; i++) cRingOut[32*i +: 32] = $urandom;
    if (dr[3]) cRingOut[127:96] = 32'hDEADBEEF;
    cSlotTypeOut = 16'($urandom);
    cSrcDestOut  = 16'($urandom);
    #2;
    w = -1;
    if (mOwner >= 0) w = mOwner;
    else if (st == Token) w = pickFrom(mPtr, rq);
    eg = (w >= 0) ? (N'(1) << w) : '0;
    eRing = RingIn; eSt = SlotTypeIn; eSd = SrcDestIn;
    if (w >= 0 && dr[w]) begin
      eRing = cRingOut[32*w +: 32];
      eSt   = cSlotTypeOut[4*w +: 4];
      eSd   = cSrcDestOut[4*w +: 4];
    end
    chk("grant", 64'(grant), 64'(eg));
    chk("RingOut", 64'(RingOut), 64'(eRing));
    chk("SlotTypeOut", 64'(SlotTypeOut), 64'(eSt));
    chk("SrcDestOut", 64'(SrcDestOut), 64'(eSd));
    chk("waiting", 64'(waiting), 64'(mWait));
    chk("timeout", 64'(timeout), 64'(mTo));
    chk("protoErr", 64'(protoErr), 64'(mErr));
    lastWin = (mOwner < 0 && w >= 0) ? w : -1;
    mTo   = 1'b0;
    mErr  = mErr | (|(dr & ~eg));
    mWait = rq & ~eg;
    if (mOwner < 0) begin
      if (w >= 0) begin mOwner = w; mHeld = 0; end
    end else begin
      mHeld++;
      if (rl[mOwner] || mHeld == MH) begin
        mTo = !rl[mOwner];
        mPtr = (mOwner + 1) % N;
        mOwner = -1;
      end
    end
    if (rst) modelReset();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [N-1:0] dr, rl, rq;
    logic [3:0] st;
    reset = 1'b1; req = '0; rel = '0; cDrive = '0;
    SlotTypeIn = Null; RingIn = '0; SrcDestIn = '0;
    cRingOut = '0; cSlotTypeOut = '0; cSrcDestOut = '0;
    @(posedge clock); #1;
    modelReset();

    // single requester
    repeat (3) runCycle(0, 4'b0001, 0, 0, Null);
    runCycle(0, 4'b0001, 0, 4'b0001, Token);
    chk("singleWin", 64'(lastWin), 64'(0));
    repeat (14) runCycle(0, 0, 0, 4'b0001, Address);
    runCycle(0, 0, 4'b0001, 4'b0001, WriteData);
    repeat (2) runCycle(0, 0, 0, 0, Null);
    chk("relGrant", 64'(grant), 64'(0));

    // fairness from a clean pointer
    runCycle(1, 0, 0, 0, Null);
    for (int t = 0; t < 8; t++) begin
      runCycle(0, 4'b1111, 0, 0, Token);
      chk("rrOrder", 64'(lastWin), 64'(t % 4));
      runCycle(0, 4'b1111, 4'(1) << (t % 4), 0, Null);
    end

    // token coincident with release
    runCycle(0, 4'b0100, 0, 0, Token);
    chk("own2", 64'(lastWin), 64'(2));
    runCycle(0, 4'b0010, 4'b0100, 0, Token);
    runCycle(0, 4'b0010, 0, 0, Null);
    chk("noRegrant", 64'(grant), 64'(0));
    runCycle(0, 4'b0010, 0, 0, Token);
    chk("late1", 64'(lastWin), 64'(1));
    runCycle(0, 0, 4'b0010, 0, Null);

    // watchdog
    toCount = 0;
    runCycle(0, 4'b0010, 0, 0, Token);
    chk("wdOwn", 64'(lastWin), 64'(1));
    for (int k = 0; k < 12; k++) begin
      runCycle(0, 4'b0011, 0, 4'b0010, Null);
      toCount += int'(timeout);
    end
    chk("timeoutOnce", 64'(toCount), 64'(1));
    runCycle(0, 4'b0011, 0, 0, Token);
    chk("wdWrap", 64'(lastWin), 64'(0));
    runCycle(0, 0, 4'b0001, 0, Null);

    // rogue driver
    runCycle(0, 0, 0, 4'b1000, Null);
    repeat (3) runCycle(0, 0, 0, 0, Null);
    chk("protoErrSticky", 64'(protoErr), 64'(1));

    // reset mid-ownership
    runCycle(0, 4'b0001, 0, 4'b0001, Token);
    repeat (3) runCycle(0, 0, 0, 4'b0001, Address);
    runCycle(1, 0, 0, 4'b0001, Address);
    chk("rstErr", 64'(protoErr), 64'(0));
    runCycle(0, 4'b0001, 0, 0, Token);
    chk("postRst", 64'(lastWin), 64'(0));
    runCycle(0, 0, 4'b0001, 0, Null);

    // randomized traffic
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 3 == 0) pend = pend | N'($urandom);
      rq = pend;
      dr = '0;
      if (mOwner >= 0 && $urandom % 4 != 0) dr = N'(1) << mOwner;
      if ($urandom % 500 == 0) dr = dr | N'($urandom);
      rl = '0;
      if (mOwner >= 0 && $urandom % 6 == 0) rl = N'(1) << mOwner;
      if ($urandom % 16 == 0) rl = rl | N'($urandom);
      case ($urandom % 8)
        0, 1:    st = Token;
        2:       st = Address;
        3:       st = WriteData;
        4:       st = ReadData;
        default: st = Null;
      endcase
      runCycle(($urandom % 300) == 0, rq, rl, dr, st);
      if (lastWin >= 0) pend[lastWin] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ring_client_arbiter.md
Name: ring_client_arbiter

Overview:
- Per-core arbiter that shares the core's single ring station between local ring clients: data/instruction cache, messenger, locker and barrier unit.
- On each arriving Token slot it grants ring ownership to one requesting client, chosen round-robin.
- While a client owns the ring, the arbiter muxes that client's outputs onto the ring. Otherwise it passes the ring through unmodified.
- It sits between the ring input/output pins of the core and the clients' ring-out buses.

Parameters:
NCLIENT, 4, number of ring clients (2..8); client 0 is the cache.
MAXHOLD, 64, watchdog limit in cycles for continuous ownership; a client still owning when the counter reaches this value is forcibly released.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
RingIn  in  32  ring data from upstream station
SlotTypeIn  in  4  slot type from upstream
SrcDestIn  in  4  source/dest from upstream
req  in  NCLIENT  client wants the ring (level, held until granted)
rel  in  NCLIENT  one-cycle pulse: owner finished its train
cRingOut  in  32*NCLIENT  per-client ring data (client i at bits 32i+31:32i)
cSlotTypeOut  in  4*NCLIENT  per-client slot type
cSrcDestOut  in  4*NCLIENT  per-client src/dest
cDrive  in  NCLIENT  client is driving its outputs
grant  out  NCLIENT  one-hot ownership, combinational
waiting  out  NCLIENT  registered; client requesting but not owner
RingOut  out  32  ring data downstream
SlotTypeOut  out  4  slot type downstream
SrcDestOut  out  4  src/dest downstream
timeout  out  1  one-cycle pulse when the watchdog forces a release
protoErr  out  1  sticky; a non-owner asserted cDrive

Behaviour:
- Reset values:
  - state HUNT; owner 0; rrPtr 0; holdCnt 0.
  - waiting 0; timeout 0; protoErr 0.
  - grant is combinational and evaluates to 0 when in HUNT with no Token present.
- The term "tokenIn" below means SlotTypeIn == Token (1).

HUNT state:
- grant[w] = 1 in the cycle where tokenIn & |req is true.
- The winner w is the first set req bit searching upward from rrPtr, wrapping modulo NCLIENT.
- The same cycle, the winner sees the token and may modify it through its outputs.
- At the next edge: owner <= w, state <= OWN, holdCnt <= 0.
- If no req is set, the Token passes through unchanged and the state stays HUNT.

OWN state:
- grant[owner] = 1. holdCnt increments each cycle, saturating at MAXHOLD.
- rel[owner] causes: state <= HUNT, rrPtr <= (owner+1) mod NCLIENT.
  - Release takes effect at the edge.
  - A Token arriving in the same cycle as rel is passed through unclaimed; there is no same-cycle regrant.
- When holdCnt == MAXHOLD-1 and no rel has arrived:
  - state <= HUNT and rrPtr advances exactly as for a release.
  - timeout pulses in the following cycle.
- rel from a non-owner is ignored. req changes during OWN are ignored.

Output mux:
- If grant[i] & cDrive[i], the outputs are client i's buses.
- Otherwise RingOut/SlotTypeOut/SrcDestOut equal RingIn/SlotTypeIn/SrcDestIn.
- The mux adds no register stage, so ring latency through the station is unchanged.

Status outputs:
- waiting[i] <= req[i] & ~grant[i] (one-cycle latency). Clients use waiting to defer tokens.
- protoErr is set when cDrive[i] & ~grant[i] for any i, and is cleared only by reset.

Other rules:
- A client re-requesting right after its release goes to the back of the round-robin order; starvation-free with a bound of NCLIENT-1 grants.
- Reset during OWN: grant drops once the reset edge is taken and the ring reverts to pass-through. An in-flight train is abandoned, and the clients' own resets clean up.
- rrPtr and owner widths are clog2(NCLIENT). Wrap arithmetic is explicit, not a power-of-two assumption.

Decomposition:
- Shared package ring_pkg holds:
  - slot type constants Null=7, Token=1, Address=2, WriteData=3, ReadData=4;
  - the ring width constants (data 32, type 4, srcdest 4).
- One sub-module, rr_pick: combinational round-robin picker. Inputs are req and rrPtr; outputs are a one-hot winner and a valid flag. It is reused by the memory-side arbiter.

Test Plan:
- Single requester: req=0001, Token with RingIn=0 at cycle 5 -> grant=0001 at cycle 5; RingOut=cRingOut[0] while cDrive[0]; rel at cycle 20 -> grant=0 at cycle 21; RingOut follows RingIn.
- Round-robin fairness: req=1111 held, 8 tokens each with an immediate rel -> grant order 0,1,2,3,0,1,2,3.
- Token arrives with rel in the same cycle: owner=2 pulses rel while SlotTypeIn=Token, req=0010 -> Token passes through unchanged; client 1 is granted only on the next Token.
- Watchdog: MAXHOLD=8, owner 1 never releases -> state HUNT after 8 OWN cycles; timeout pulses once; next Token with req=0011 grants client 0 (rrPtr=2, wraps to 0).
- Protocol error and pass-through: no grant, cDrive[3]=1 with cRingOut[3]=0xDEADBEEF -> RingOut=RingIn; protoErr=1 next cycle and stays 1 until reset.
- Reset mid-ownership: owner 0 driving, reset asserted for 1 cycle -> grant=0, waiting=0, protoErr=0 after the edge; the next Token with req=0001 is granted normally.
